// File: rtl/cpu_debugger_pkg.sv
// Shared definitions for the CPU debugger memory sequencer and the MCU
// debugger port: access direction encoding, sequencer state type and
// default datapath widths.
package cpu_debugger_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 16;

  // Direction encoding used on both the command and the debugger port.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_WR_ACCESS,
    ST_RD_ACCESS,
    ST_RD_CAPTURE,
    ST_RD_HOLD,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/cpu_debugger_mem_sequencer.sv
// Block read/write sequencer for the MCU debugger memory port.
// Accepts one command (rw, start address, byte count) and performs one
// debugger access per byte with an incrementing (wrapping) address.
// Ports:
//   i_clk, i_reset_n           clock, asynchronous active-low reset
//   i_cmd_*/o_cmd_ready        command handshake (ready only in IDLE)
//   i_abort                    terminate the current command
//   i_wr_*/o_wr_ready          write byte stream (valid/ready)
//   o_rd_*/i_rd_ready          read byte stream (valid/ready)
//   o_debugger_*/i_debugger_data  MCU debugger port, 1-cycle read latency
//   o_busy, o_done             status: not idle, end-of-command pulse
//   o_checksum                 mod-2^DATA_WIDTH sum of transferred bytes,
//                              present only with CPU_DEBUGGER_SEQ_CHECKSUM_EN
module cpu_debugger_mem_sequencer
  import cpu_debugger_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_rw,
  input  logic [ADDR_WIDTH-1:0] i_cmd_address,
  input  logic [LEN_WIDTH-1:0]  i_cmd_length,
  input  logic                  i_abort,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_debugger_en,
  output logic                  o_debugger_rw,
  output logic [ADDR_WIDTH-1:0] o_debugger_address,
  output logic [DATA_WIDTH-1:0] o_debugger_data,
  input  logic [DATA_WIDTH-1:0] i_debugger_data,
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] o_checksum,
`endif
  output logic                  o_busy,
  output logic                  o_done
);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  // Remembers an abort seen while an access is in flight so the command
  // ends after that byte's step instead of continuing.
  logic                  abort_pend_q, abort_pend_d;
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    rd_data_d    = rd_data_q;
    abort_pend_d = abort_pend_q;
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // o_cmd_ready is high exactly in IDLE, so valid alone completes the handshake.
        if (i_cmd_valid) begin
          addr_d       = i_cmd_address;
          cnt_d        = i_cmd_length;
          abort_pend_d = 1'b0;
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
          csum_d       = '0;
`endif
          if (i_cmd_length == '0)      state_d = ST_DONE;
          else if (i_cmd_rw == RW_READ) state_d = ST_RD_ACCESS;
          else                          state_d = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (i_abort) begin
          state_d = ST_DONE;
        end else if (i_wr_valid) begin
          data_d  = i_wr_data;
          state_d = ST_WR_ACCESS;
        end
      end
      ST_WR_ACCESS: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        cnt_d  = cnt_q - LEN_WIDTH'(1);
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
        csum_d = csum_q + data_q;
`endif
        if (cnt_q == LEN_WIDTH'(1) || i_abort || abort_pend_q) state_d = ST_DONE;
        else                                                   state_d = ST_WR_WAIT;
      end
      ST_RD_ACCESS: begin
        if (i_abort) abort_pend_d = 1'b1;
        state_d = ST_RD_CAPTURE;
      end
      ST_RD_CAPTURE: begin
        rd_data_d = i_debugger_data;
        addr_d    = addr_q + ADDR_WIDTH'(1);
        cnt_d     = cnt_q - LEN_WIDTH'(1);
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
        csum_d    = csum_q + i_debugger_data;
`endif
        if (i_abort || abort_pend_q) state_d = ST_DONE;
        else                         state_d = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (i_abort)              state_d = ST_DONE;
        else if (i_rd_ready)      state_d = (cnt_q == '0) ? ST_DONE : ST_RD_ACCESS;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so none of them has a
  // combinational path from an input.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q            <= ST_IDLE;
      addr_q             <= '0;
      cnt_q              <= '0;
      data_q             <= '0;
      rd_data_q          <= '0;
      abort_pend_q       <= 1'b0;
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
      csum_q             <= '0;
`endif
      o_cmd_ready        <= 1'b1;
      o_wr_ready         <= 1'b0;
      o_rd_valid         <= 1'b0;
      o_debugger_en      <= 1'b0;
      o_debugger_rw      <= 1'b0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
    end else begin
      state_q            <= state_d;
      addr_q             <= addr_d;
      cnt_q              <= cnt_d;
      data_q             <= data_d;
      rd_data_q          <= rd_data_d;
      abort_pend_q       <= abort_pend_d;
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
      csum_q             <= csum_d;
`endif
      o_cmd_ready        <= (state_d == ST_IDLE);
      o_wr_ready         <= (state_d == ST_WR_WAIT);
      o_rd_valid         <= (state_d == ST_RD_HOLD);
      o_debugger_en      <= (state_d == ST_WR_ACCESS) || (state_d == ST_RD_ACCESS);
      o_debugger_rw      <= (state_d == ST_RD_ACCESS);
      o_busy             <= (state_d != ST_IDLE);
      o_done             <= (state_d == ST_DONE);
    end
  end

  assign o_debugger_address = addr_q;
  assign o_debugger_data    = data_q;
  assign o_rd_data          = rd_data_q;
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
  assign o_checksum         = csum_q;
`endif

endmodule

// File: tb/tb_cpu_debugger_mem_sequencer.sv
// Self-checking bench for cpu_debugger_mem_sequencer: directed scenarios
// plus randomized commands checked against a transaction-level model.
module tb_cpu_debugger_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_valid, i_cmd_rw, i_abort, i_wr_valid, i_rd_ready;
  logic [15:0] i_cmd_address, i_cmd_length;
  logic [7:0]  i_wr_data, mem_rd;
  logic        o_cmd_ready, o_wr_ready, o_rd_valid, o_debugger_en, o_debugger_rw, o_busy, o_done;
  logic [7:0]  o_rd_data, o_debugger_data;
  logic [15:0] o_debugger_address;
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
  logic [7:0]  o_checksum;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu_debugger_mem_sequencer dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_rw(i_cmd_rw),
    .i_cmd_address(i_cmd_address), .i_cmd_length(i_cmd_length), .i_abort(i_abort),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .o_debugger_en(o_debugger_en), .o_debugger_rw(o_debugger_rw),
    .o_debugger_address(o_debugger_address), .o_debugger_data(o_debugger_data),
    .i_debugger_data(mem_rd),
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
    .o_checksum(o_checksum),
`endif
    .o_busy(o_busy), .o_done(o_done)
  );

  // Memory model: content is a keyed function of the address, returned one cycle later.
  logic [7:0] key = 8'h00;
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ key;
  endfunction
  always @(posedge clk) mem_rd <= mem_f(o_debugger_address);

  // Observations of the last command run by do_cmd.
  logic [15:0] acc_addr[$];
  logic        acc_rw[$];
  logic [7:0]  acc_data[$];
  logic [7:0]  rd_got[$];
  logic [7:0]  wq[$];
  int          adj_err, stab_err, done_cyc, abort_cyc;
  bit          seen_done, fired;
  logic [7:0]  csum_done;

  // Runs one command; wq must hold at least len write bytes.
  task automatic do_cmd(input logic rw, input logic [15:0] addr, input int len,
                        input int wr_pct, input int rdy_pct, input int abort_n);
    int sent, cyc;
    logic prev_en, pend;
    logic [7:0] pd;
    acc_addr.delete(); acc_rw.delete(); acc_data.delete(); rd_got.delete();
    adj_err = 0; stab_err = 0; seen_done = 0; fired = 0; done_cyc = -1; abort_cyc = -1;
    csum_done = 8'h00; sent = 0; cyc = 0; prev_en = 0; pend = 0; pd = 8'h00;
    while (!o_cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    i_cmd_valid = 1; i_cmd_rw = rw; i_cmd_address = addr; i_cmd_length = 16'(len);
    @(negedge clk);
    cyc = 0;
    while (!seen_done && cyc < 1000) begin
      if (o_debugger_en) begin
        acc_addr.push_back(o_debugger_address);
        acc_rw.push_back(o_debugger_rw);
        acc_data.push_back(o_debugger_data);
        if (prev_en) adj_err++;
      end
      prev_en = o_debugger_en;
      if (pend && (!o_rd_valid || o_rd_data !== pd)) stab_err++;
      if (o_done) begin
        seen_done = 1; done_cyc = cyc;
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
        csum_done = o_checksum;
`endif
      end
      // Noise on the command port while busy must be ignored.
      i_cmd_valid = !seen_done && ($urandom_range(1) == 1);
      i_cmd_rw = 1'($urandom); i_cmd_address = 16'($urandom); i_cmd_length = 16'($urandom);
      i_abort = seen_done ? 1'($urandom) : 1'b0;
      if (abort_n >= 0 && !fired && (o_wr_ready || o_rd_valid) &&
          (sent + rd_got.size()) == abort_n) begin
        i_abort = 1; fired = 1; abort_cyc = cyc;
      end
      i_wr_valid = ($urandom_range(99) < wr_pct);
      i_wr_data  = (sent < len) ? wq[sent] : 8'($urandom);
      i_rd_ready = ($urandom_range(99) < rdy_pct);
      if (!i_abort && o_wr_ready && i_wr_valid) sent++;
      if (!i_abort && o_rd_valid && i_rd_ready) rd_got.push_back(o_rd_data);
      pend = o_rd_valid && !i_abort && !i_rd_ready;
      pd = o_rd_data;
      cyc++;
      @(negedge clk);
    end
    i_cmd_valid = 0; i_abort = 0; i_wr_valid = 0; i_rd_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_cmd_ready, o_wr_ready, o_rd_valid, o_debugger_en, o_debugger_rw, o_busy, o_done} !== 7'b1000000 ||
        o_debugger_address !== 16'h0 || o_debugger_data !== 8'h0 || o_rd_data !== 8'h0) begin
      bad++;
      $display("FAIL reset_values: ready=%b wr=%b rv=%b en=%b rw=%b busy=%b done=%b addr=%h data=%h rd=%h, want 1000000 and zeros",
               o_cmd_ready, o_wr_ready, o_rd_valid, o_debugger_en, o_debugger_rw, o_busy, o_done,
               o_debugger_address, o_debugger_data, o_rd_data);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    total++;
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: ready=%b busy=%b want 1 0", o_cmd_ready, o_busy);
    end
  endtask

  task automatic test_write_basic();
    wq.delete(); wq.push_back(8'hA1); wq.push_back(8'hB2); wq.push_back(8'hC3);
    do_cmd(1'b0, 16'h0200, 3, 100, 100, -1);
    total++;
    if (!seen_done || acc_addr.size() != 3) begin
      bad++; $display("FAIL wr_basic_count: done=%0d accesses=%0d want 1 3", seen_done, acc_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (acc_addr[i] !== 16'h0200 + 16'(i) || acc_rw[i] !== 1'b0 || acc_data[i] !== wq[i]) begin
          bad++; $display("FAIL wr_basic_access%0d: addr=%h rw=%b data=%h want %h 0 %h",
                          i, acc_addr[i], acc_rw[i], acc_data[i], 16'h0200 + 16'(i), wq[i]);
        end
      end
    end
    total++;
    if (adj_err != 0 || o_done !== 1'b0 || o_cmd_ready !== 1'b1) begin
      bad++; $display("FAIL wr_basic_spacing: adjacent_en=%0d done_after=%b ready=%b want 0 0 1",
                      adj_err, o_done, o_cmd_ready);
    end
  endtask

  task automatic test_read_wrap();
    key = 8'h00;
    do_cmd(1'b1, 16'hFFFE, 3, 100, 100, -1);
    total++;
    if (!seen_done || acc_addr.size() != 3 || rd_got.size() != 3) begin
      bad++; $display("FAIL rd_wrap_count: done=%0d accesses=%0d bytes=%0d want 1 3 3",
                      seen_done, acc_addr.size(), rd_got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [15:0] ea;
        ea = 16'hFFFE + 16'(i);
        total++;
        if (acc_addr[i] !== ea || acc_rw[i] !== 1'b1 || rd_got[i] !== ea[7:0]) begin
          bad++; $display("FAIL rd_wrap_byte%0d: addr=%h rw=%b data=%h want %h 1 %h",
                          i, acc_addr[i], acc_rw[i], rd_got[i], ea, ea[7:0]);
        end
      end
    end
    total++;
    if (adj_err != 0) begin bad++; $display("FAIL rd_wrap_spacing: adjacent_en=%0d want 0", adj_err); end
  endtask

  task automatic test_read_backpressure();
    int cyc;
    logic [7:0] d;
    key = 8'h5A;
    i_rd_ready = 0;
    i_cmd_valid = 1; i_cmd_rw = 1; i_cmd_address = 16'h1234; i_cmd_length = 16'd2;
    @(negedge clk);
    i_cmd_valid = 0;
    cyc = 0;
    while (!o_rd_valid && cyc < 20) begin @(negedge clk); cyc++; end
    d = o_rd_data;
    total++;
    if (!o_rd_valid || d !== mem_f(16'h1234)) begin
      bad++; $display("FAIL bp_first_byte: valid=%b data=%h want 1 %h", o_rd_valid, d, mem_f(16'h1234));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== d || o_debugger_en !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: valid=%b data=%h en=%b want 1 %h 0", i, o_rd_valid, o_rd_data, o_debugger_en, d);
      end
    end
    i_rd_ready = 1;
    @(negedge clk);
    i_rd_ready = 0;
    total++;
    if (o_rd_valid !== 1'b0 || o_debugger_en !== 1'b1 || o_debugger_address !== 16'h1235) begin
      bad++; $display("FAIL bp_second_access: valid=%b en=%b addr=%h want 0 1 1235", o_rd_valid, o_debugger_en, o_debugger_address);
    end
    cyc = 0;
    while (!o_rd_valid && cyc < 20) begin @(negedge clk); cyc++; end
    total++;
    if (o_rd_data !== mem_f(16'h1235)) begin
      bad++; $display("FAIL bp_second_byte: data=%h want %h", o_rd_data, mem_f(16'h1235));
    end
    i_rd_ready = 1;
    cyc = 0;
    while (!o_done && cyc < 20) begin @(negedge clk); cyc++; end
    i_rd_ready = 0;
    total++;
    if (o_done !== 1'b1) begin bad++; $display("FAIL bp_done: done=%b want 1", o_done); end
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    i_cmd_valid = 1; i_cmd_rw = 0; i_cmd_address = 16'h4000; i_cmd_length = 16'd0;
    @(negedge clk);
    i_cmd_valid = 0;
    total++;
    if (o_cmd_ready !== 1'b0 || o_done !== 1'b1 || o_debugger_en !== 1'b0 || o_busy !== 1'b1) begin
      bad++; $display("FAIL zero_len_done: ready=%b done=%b en=%b busy=%b want 0 1 0 1", o_cmd_ready, o_done, o_debugger_en, o_busy);
    end
    @(negedge clk);
    total++;
    if (o_cmd_ready !== 1'b1 || o_done !== 1'b0 || o_debugger_en !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL zero_len_idle: ready=%b done=%b en=%b busy=%b want 1 0 0 0", o_cmd_ready, o_done, o_debugger_en, o_busy);
    end
  endtask

  task automatic test_write_abort();
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(8'($urandom));
    do_cmd(1'b0, 16'h0300, 4, 100, 100, 2);
    total++;
    if (!fired || acc_addr.size() != 2 || done_cyc != abort_cyc + 1) begin
      bad++; $display("FAIL wr_abort: fired=%0d accesses=%0d done_cyc=%0d abort_cyc=%0d want 1 2 abort+1",
                      fired, acc_addr.size(), done_cyc, abort_cyc);
    end
    total++;
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
      bad++; $display("FAIL wr_abort_idle: ready=%b busy=%b want 1 0", o_cmd_ready, o_busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    i_rd_ready = 0;
    i_cmd_valid = 1; i_cmd_rw = 1; i_cmd_address = 16'h0010; i_cmd_length = 16'd2;
    @(negedge clk);
    i_cmd_valid = 0;
    cyc = 0;
    while (!o_rd_valid && cyc < 20) begin @(negedge clk); cyc++; end
    #2 rst_n = 0;
    #1;
    total++;
    if (o_rd_valid !== 1'b0 || o_debugger_en !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid: rv=%b en=%b busy=%b ready=%b want 0 0 0 1", o_rd_valid, o_debugger_en, o_busy, o_cmd_ready);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
  task automatic test_checksum();
    wq.delete(); wq.push_back(8'h80); wq.push_back(8'h90);
    do_cmd(1'b0, 16'h0050, 2, 100, 100, -1);
    total++;
    if (!seen_done || csum_done !== 8'h10) begin
      bad++; $display("FAIL checksum_fixed: done=%0d csum=%h want 1 10", seen_done, csum_done);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic rw;
      logic [15:0] addr;
      int len, abort_n, acc_exp, rd_exp, errs;
      logic [7:0] sum;
      rw   = 1'($urandom_range(1));
      addr = ($urandom_range(1) == 1) ? 16'hFFFF - 16'($urandom_range(3)) : 16'($urandom);
      len  = $urandom_range(6);
      key  = 8'($urandom);
      wq.delete();
      for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
      abort_n = (len > 1 && $urandom_range(2) == 0) ? $urandom_range(len - 1) : -1;
      do_cmd(rw, addr, len, $urandom_range(40, 100), $urandom_range(30, 100), abort_n);
      if (abort_n >= 0) acc_exp = rw ? abort_n + 1 : abort_n;
      else              acc_exp = len;
      rd_exp = rw ? ((abort_n >= 0) ? abort_n : len) : 0;
      total++;
      if (!seen_done || acc_addr.size() != acc_exp || rd_got.size() != rd_exp) begin
        bad++; $display("FAIL rand%0d_counts: done=%0d accesses=%0d bytes=%0d want 1 %0d %0d",
                        n, seen_done, acc_addr.size(), rd_got.size(), acc_exp, rd_exp);
        continue;
      end
      errs = 0;
      sum  = 8'h00;
      for (int i = 0; i < acc_exp; i++) begin
        logic [15:0] ea;
        ea = addr + 16'(i);
        if (acc_addr[i] !== ea || acc_rw[i] !== rw) errs++;
        if (!rw && acc_data[i] !== wq[i]) errs++;
        if (rw && i < rd_exp && rd_got[i] !== mem_f(ea)) errs++;
        sum = sum + (rw ? mem_f(ea) : wq[i]);
      end
      total++;
      if (errs != 0) begin
        bad++; $display("FAIL rand%0d_data: rw=%b addr=%h len=%0d wrong_items=%0d want 0", n, rw, addr, len, errs);
      end
      total++;
      if (adj_err != 0 || stab_err != 0 || fired != (abort_n >= 0) || o_cmd_ready !== 1'b1) begin
        bad++; $display("FAIL rand%0d_proto: adjacent_en=%0d unstable=%0d fired=%0d ready=%b want 0 0 %0d 1",
                        n, adj_err, stab_err, fired, o_cmd_ready, abort_n >= 0);
      end
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
      total++;
      if (csum_done !== sum) begin
        bad++; $display("FAIL rand%0d_checksum: csum=%h want %h", n, csum_done, sum);
      end
`endif
    end
  endtask

  initial begin
    i_cmd_valid = 0; i_cmd_rw = 0; i_cmd_address = 0; i_cmd_length = 0;
    i_abort = 0; i_wr_valid = 0; i_wr_data = 0; i_rd_ready = 0;
    test_reset();
    test_write_basic();
    test_read_wrap();
    test_read_backpressure();
    test_zero_len();
    test_write_abort();
    test_reset_mid();
`ifdef CPU_DEBUGGER_SEQ_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
